ntt_ctrl: RTL

NTT_CTRL -- requirements
Module: ntt_ctrl

---
 rtl/ntt_ctrl_pkg.sv | 19 +
 rtl/ntt_delay_line.sv | 37 +++
 rtl/ntt_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ntt_ctrl_pkg.sv
// Shared definitions for the NTT controller: FSM state encoding and size/latency defaults.
`ifndef RING_SIZE
`define RING_SIZE 8
`endif

package ntt_ctrl_pkg;

  localparam int unsigned RING_SIZE_DEF = `RING_SIZE;
  localparam int unsigned LOG_N_DEF     = $clog2(RING_SIZE_DEF);
  localparam int unsigned CORE_LAT_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/ntt_delay_line.sv
// Fixed-depth shift pipeline with reset; carries write-back valid and addresses.
module ntt_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];
  logic [WIDTH-1:0] pipe_d [DEPTH];

  always_comb begin
    pipe_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Clearing every slot guarantees no write-back escapes after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_ctrl.sv
// Forward NTT sequencer: issues one butterfly per cycle per stage, drains the core
// between stages, and replays read addresses as write-back addresses CORE_LAT later.
module ntt_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int unsigned LOG_N    = LOG_N_DEF,
  parameter int unsigned CORE_LAT = CORE_LAT_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [LOG_N-1:0]           rd_addr_a,
  output logic [LOG_N-1:0]           rd_addr_b,
  output logic [LOG_N-1:0]           tw_addr,
  output logic                       wr_en,
  output logic [LOG_N-1:0]           wr_addr_a,
  output logic [LOG_N-1:0]           wr_addr_b,
  output logic [$clog2(LOG_N+1)-1:0] stage
);

  localparam int unsigned SW   = $clog2(LOG_N + 1);
  localparam int unsigned HALF = 1 << (LOG_N - 1);
  localparam int unsigned CW   = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam int unsigned DW   = 2 * LOG_N + 1;

  localparam logic [LOG_N-1:0] J_LAST     = LOG_N'(HALF - 1);
  localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG_N - 1);
  localparam logic [CW-1:0]    DRAIN_LAST = CW'(CORE_LAT - 1);

  state_e           state_q, state_d;
  logic [LOG_N-1:0] j_q, j_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] rd_a_q, rd_a_d;
  logic [LOG_N-1:0] rd_b_q, rd_b_d;
  logic [LOG_N-1:0] tw_q, tw_d;
  logic [LOG_N-1:0] m_c, g_c, k_c;
  logic [DW-1:0]    wb_out;

  // Next state plus registered outputs derived from the upcoming state/counters.
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    rd_a_d  = '0;
    rd_b_d  = '0;
    tw_d    = '0;
    m_c     = '0;
    g_c     = '0;
    k_c     = '0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_ISSUE;
          j_d     = '0;
          stage_d = '0;
        end
      end
      ST_ISSUE: begin
        if (j_q == J_LAST) begin
          state_d = ST_DRAIN;
          j_d     = '0;
          cnt_d   = '0;
        end else begin
          j_d = j_q + LOG_N'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d  = (state_d == ST_DONE);
    rd_en_d = (state_d == ST_ISSUE);

    // Butterfly span m = N>>(s+1) = HALF>>s; group index g and offset k split j.
    if (rd_en_d) begin
      m_c    = LOG_N'(HALF) >> stage_d;
      g_c    = j_d >> (SW'(LOG_N - 1) - stage_d);
      k_c    = j_d & (m_c - LOG_N'(1));
      rd_a_d = (g_c << (SW'(LOG_N) - stage_d)) + k_c;
      rd_b_d = rd_a_d + m_c;
      tw_d   = (LOG_N'(1) << stage_d) + g_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
    end
  end

  ntt_delay_line #(
    .DEPTH (CORE_LAT),
    .WIDTH (DW)
  ) u_wb_dly (
    .clk   (clk),
    .reset (reset),
    .din   ({rd_en_q, rd_a_q, rd_b_q}),
    .dout  (wb_out)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = wb_out;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;
  assign stage     = stage_q;

endmodule
